// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the shift-add multiplier slice.
//   state_t            : controller states IDLE / RUN / DONE
//   MULT_WIDTH_DEFAULT : default operand width
//   cnt_width()        : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MULT_WIDTH_DEFAULT = 8;

   // One extra bit over log2 so the counter can represent WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mult_addsub_n.sv
// -----------------------------------------------------------------------------
// mult_addsub_n
// Combinational (WIDTH+1)-bit adder/subtractor used by one shift-add step.
// Ports:
//   acc         in  WIDTH+1  partial product high part {X,A}
//   s           in  WIDTH    multiplicand
//   sub         in  1        1: acc - s, 0: acc + s
//   signed_mode in  1        1: operands sign-extended, 0: zero-extended
//   sum         out WIDTH+1  result, overflow beyond WIDTH+1 bits dropped
// -----------------------------------------------------------------------------
module mult_addsub_n
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] s,
   input  logic             sub,
   input  logic             signed_mode,
   output logic [WIDTH:0]   sum
);

   logic signed [WIDTH:0] acc_ext;
   logic signed [WIDTH:0] op_ext;

   always_comb begin
      // In unsigned mode the X bit is always 0, so the top bit is forced clear.
      acc_ext = signed_mode ? acc : {1'b0, acc[WIDTH-1:0]};
      op_ext  = signed_mode ? {s[WIDTH-1], s} : {1'b0, s};
      sum     = sub ? (acc_ext - op_ext) : (acc_ext + op_ext);
   end

endmodule

// File: rtl/shift_add_mult_n.sv
// -----------------------------------------------------------------------------
// shift_add_mult_n
// Sequential shift-add multiplier with its own IDLE/RUN/DONE controller.
// Multiplies D (latched as S at Start) by the preloaded B in WIDTH cycles;
// the product is {A,B}, with X holding the product sign (signed build) or the
// final carry, which is always 0 (unsigned build).
//
// Build option: define MULT_SIGNED_EN for two's-complement operands
// (last step subtracts for the MSB weight). Undefined gives unsigned mode.
//
// Ports:
//   Clk      in   1      system clock, rising edge
//   Reset_n  in   1      asynchronous active-low reset
//   Clear_A  in   1      in IDLE: clear A and X
//   Load_B   in   1      in IDLE: B <= D
//   Start    in   1      level request to multiply, sampled in IDLE
//   D        in   WIDTH  operand bus (B source for Load_B, S source at Start)
//   A        out  WIDTH  accumulator / product high half
//   B        out  WIDTH  multiplier / product low half
//   X        out  1      sign-extension bit of A (signed) or carry (unsigned)
//   Busy     out  1      high while in RUN (registered, after edges 1..WIDTH-1)
//   Done     out  1      high while in DONE
// -----------------------------------------------------------------------------
module shift_add_mult_n
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Clear_A,
   input  logic             Load_B,
   input  logic             Start,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef MULT_SIGNED_EN
   localparam logic SIGNED_MODE = 1'b1;
`else
   localparam logic SIGNED_MODE = 1'b0;
`endif

   state_t state, state_next;

   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic             x_q;
   logic [CW-1:0]    count_q;
   logic             busy_q, done_q;

   logic             last_step;
   logic             sub_sel;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shift_src;
   logic             x_shift;
   logic [WIDTH-1:0] a_shift, b_shift;

   assign last_step = (count_q == LAST_STEP);
   // Only the signed build corrects the MSB weight by subtracting on the last step.
   assign sub_sel   = SIGNED_MODE & last_step;

   mult_addsub_n #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .acc         ({x_q, a_q}),
      .s           (s_q),
      .sub         (sub_sel),
      .signed_mode (SIGNED_MODE),
      .sum         (sum)
   );

   // One step: optionally accumulate, then arithmetic-shift {X,A,B} right.
   always_comb begin
      shift_src = b_q[0] ? sum : {x_q, a_q};
      x_shift   = SIGNED_MODE ? shift_src[WIDTH] : 1'b0;
      a_shift   = {shift_src[WIDTH], shift_src[WIDTH-1:1]};
      b_shift   = {shift_src[0], b_q[WIDTH-1:1]};
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start)     state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (!Start)    state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         // Busy lags the state by one edge, so it drops on the edge entering DONE.
         busy_q <= (state == RUN) && (state_next == RUN);
         done_q <= (state_next == DONE);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         x_q     <= 1'b0;
         count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  s_q     <= D;
                  a_q     <= '0;
                  x_q     <= 1'b0;
                  count_q <= '0;
               end else begin
                  if (Load_B) b_q <= D;
                  if (Clear_A) begin
                     a_q <= '0;
                     x_q <= 1'b0;
                  end
               end
            end
            RUN: begin
               x_q     <= x_shift;
               a_q     <= a_shift;
               b_q     <= b_shift;
               count_q <= count_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign A    = a_q;
   assign B    = b_q;
   assign X    = x_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_shift_add_mult_n.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult_n
// Self-checking bench for shift_add_mult_n. Two instances (WIDTH=8 and 16)
// share the control inputs; each operation is checked on the instance of the
// width under test. Expected {X,A,B} values come from an arithmetic product
// model and travel through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_shift_add_mult_n;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear_a = 1'b0;
   logic        load_b = 1'b0;
   logic        start = 1'b0;
   logic [31:0] d = '0;

   logic [7:0]  a8, b8;
   logic        x8, busy8, done8;
   logic [15:0] a16, b16;
   logic        x16, busy16, done16;

   int n_checks = 0;
   int n_errors = 0;
   logic [64:0] sb[$];

   always #5 clk = ~clk;

   shift_add_mult_n #(.WIDTH(8)) dut8 (
      .Clk (clk), .Reset_n (rst_n), .Clear_A (clear_a), .Load_B (load_b),
      .Start (start), .D (d[7:0]), .A (a8), .B (b8), .X (x8),
      .Busy (busy8), .Done (done8)
   );

   shift_add_mult_n #(.WIDTH(16)) dut16 (
      .Clk (clk), .Reset_n (rst_n), .Clear_A (clear_a), .Load_B (load_b),
      .Start (start), .D (d[15:0]), .A (a16), .B (b16), .X (x16),
      .Busy (busy16), .Done (done16)
   );

   task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected {X,A,B} as a (2w+1)-bit value.
   function automatic logic [64:0] model(input int w, input logic [31:0] b, input logic [31:0] s);
      longint bv, sv, mask_w;
      logic [64:0] p, mask;
      mask_w = (longint'(1) << w) - 1;
      bv = longint'(b) & mask_w;
      sv = longint'(s) & mask_w;
`ifdef MULT_SIGNED_EN
      if (((bv >> (w - 1)) & 1) != 0) bv = bv - (longint'(1) << w);
      if (((sv >> (w - 1)) & 1) != 0) sv = sv - (longint'(1) << w);
`endif
      p = 65'(bv * sv);
      mask = (65'(1) << (2 * w + 1)) - 65'(1);
      return p & mask;
   endfunction

   function automatic logic [64:0] obs(input int w);
      if (w == 8) return {48'b0, x8, a8, b8};
      return {32'b0, x16, a16, b16};
   endfunction

   function automatic logic busy_of(input int w);
      return (w == 8) ? busy8 : busy16;
   endfunction

   function automatic logic done_of(input int w);
      return (w == 8) ? done8 : done16;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load_b(input logic [31:0] v);
      d = v;
      load_b = 1'b1;
      tick();
      load_b = 1'b0;
   endtask

   // Run one multiply of S=s on width w; b_exp is the B value the DUT should use.
   task automatic run_op(input int w, input logic [31:0] s, input logic [31:0] b_exp,
                         input int hold, input bit pulse_run, input bit load_with_start);
      int lat;
      int bc;
      logic [64:0] res;
      logic [64:0] exp;
      sb.push_back(model(w, b_exp, s));
      d = s;
      start = 1'b1;
      load_b = load_with_start;
      tick();                       // edge 0: Start sampled
      load_b = 1'b0;
      d = $urandom;
      lat = 0;
      bc = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         lat = k;
         if (busy_of(w)) bc++;
         load_b  = pulse_run && (k == 2);
         clear_a = pulse_run && (k == 2);
         if (done_of(w)) break;
      end
      load_b = 1'b0;
      clear_a = 1'b0;
      check_val("latency", 65'(lat), 65'(w));
      check_val("busy_cycles", 65'(bc), 65'(w - 1));
      exp = sb.pop_front();
      res = obs(w);
      check_val("product", res, exp);
      if (hold > 0) begin
         bc = 0;
         for (int k = 0; k < hold; k++) begin
            tick();
            if (busy_of(w)) bc++;
         end
         check_val("hold_no_retrigger", 65'(bc), 65'(0));
         check_val("hold_done", 65'(done_of(w)), 65'(1));
         check_val("hold_frozen", obs(w), res);
      end
      start = 1'b0;
      tick();
      check_val("done_clear", 65'(done_of(w)), 65'(0));
      repeat (18) tick();
   endtask

   initial begin
      logic [31:0] b_prev;
      logic [31:0] rb, rs;

      #3 rst_n = 1'b0;
      #1;
      check_val("reset_obs8", obs(8), 65'(0));
      check_val("reset_obs16", obs(16), 65'(0));
      check_val("reset_busy", 65'({busy8, busy16}), 65'(0));
      check_val("reset_done", 65'({done8, done16}), 65'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      do_load_b(32'hFD);
      run_op(8, 32'h07, 32'hFD, 0, 0, 0);
      do_load_b(32'h80);
      run_op(8, 32'h80, 32'h80, 0, 0, 0);
      do_load_b(32'h80);
      run_op(8, 32'h7F, 32'h80, 0, 0, 0);
      do_load_b(32'hFF);
      run_op(8, 32'hFF, 32'hFF, 0, 0, 0);

      // Start held ~20 cycles: one multiply only, Done held until Start drops.
      do_load_b(32'h12);
      run_op(8, 32'h34, 32'h12, 12, 0, 0);
      // Load_B/Clear_A pulsed mid-RUN with garbage on D.
      do_load_b(32'h9C);
      run_op(8, 32'h65, 32'h9C, 0, 1, 0);
      // Start together with Load_B: old B must be used.
      do_load_b(32'h0B);
      run_op(8, 32'h0D, 32'h0B, 0, 0, 1);
      // Chained: B still holds the previous low half.
      b_prev = 32'(model(8, 32'h0B, 32'h0D) & 65'hFF);
      run_op(8, 32'h03, b_prev, 0, 0, 0);

      do_load_b(32'hFFFF);
      run_op(16, 32'hFFFF, 32'hFFFF, 0, 0, 0);
      do_load_b(32'h8001);
      run_op(16, 32'h7FFF, 32'h8001, 0, 0, 0);

      for (int i = 0; i < 4; i++) begin
         rb = $urandom_range(0, 255);
         rs = $urandom_range(0, 255);
         do_load_b(rb);
         run_op(8, rs, rb, 0, 0, 0);
      end

      // Asynchronous reset in the middle of RUN.
      do_load_b(32'h5A);
      d = 32'h33;
      start = 1'b1;
      tick();
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      check_val("midrun_rst_obs", obs(8), 65'(0));
      check_val("midrun_rst_busy", 65'(busy8), 65'(0));
      check_val("midrun_rst_done", 65'(done8), 65'(0));
      start = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_val("post_rst_idle", 65'({busy8, done8}), 65'(0));
      do_load_b(32'h0F);
      run_op(8, 32'hF1, 32'h0F, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
